// File: rtl/life_gen_if.sv
// life_gen_if
// Bundles the control and data signals between the board set-up stage
// (master) and the Conway generation engine (slave).
//   load      : pulse, capture board_i as the current board
//   board_i   : board from set-up stage, cell (r,c) = bit r*COLS+c
//   step      : pulse, compute one generation
//   run       : level, free-run enable
//   tick      : pace pulse, honoured only while run=1
//   board_o   : current (committed) generation
//   busy      : high while a generation is being computed
//   gen_done  : one-cycle pulse after each commit
//   gen_count : generations since last load, wraps to 0
//   extinct   : committed board is all zero
//   stable    : committed board equals the previous board
interface life_gen_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
);
  logic                 load;
  logic [ROWS*COLS-1:0] board_i;
  logic                 step;
  logic                 run;
  logic                 tick;
  logic [ROWS*COLS-1:0] board_o;
  logic                 busy;
  logic                 gen_done;
  logic [GEN_W-1:0]     gen_count;
  logic                 extinct;
  logic                 stable;

  modport master (
    output load, board_i, step, run, tick,
    input  board_o, busy, gen_done, gen_count, extinct, stable
  );

  modport slave (
    input  load, board_i, step, run, tick,
    output board_o, busy, gen_done, gen_count, extinct, stable
  );
endinterface

// File: rtl/life_gen_engine.sv
// life_gen_engine
// Captures an edited ROWS x COLS board and computes Conway successor
// generations, one row per clock, into a shadow buffer that is committed
// to board_o in a single cycle once all rows are done.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : life_gen_if.slave (load/board_i/step/run/tick in,
//           board_o/busy/gen_done/gen_count/extinct/stable out)
// Build option:
//   LIFE_WRAP_EN defined   -> toroidal board (edges wrap around)
//   LIFE_WRAP_EN undefined -> cells outside the grid count as dead
module life_gen_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
) (
  input  logic      clk,
  input  logic      reset,
  life_gen_if.slave bus
);

  localparam int CELLS = ROWS * COLS;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] row_cnt;
  logic [CELLS-1:0] board_r;
  logic             busy_r;
  logic             gen_done_r;
  logic [GEN_W-1:0] gen_count_r;
  logic             extinct_r;
  logic             stable_r;

  logic [COLS-1:0]  cur_rows  [ROWS];
  logic [COLS-1:0]  next_rows [ROWS];
  logic [CELLS-1:0] next_flat;

  logic             first_row;
  logic             last_row;
  logic [COLS-1:0]  up_row;
  logic [COLS-1:0]  mid_row;
  logic [COLS-1:0]  dn_row;
  logic [COLS+1:0]  up_e;
  logic [COLS+1:0]  mid_e;
  logic [COLS+1:0]  dn_e;
  logic [3:0]       ncnt [COLS];
  logic [COLS-1:0]  row_next;

  // Row views of the committed board and the shadow buffer
  for (genvar g = 0; g < ROWS; g++) begin : g_rows
    assign cur_rows[g]               = board_r[g*COLS +: COLS];
    assign next_flat[g*COLS +: COLS] = next_rows[g];
  end

  assign first_row = (row_cnt == '0);
  assign last_row  = (row_cnt == ROW_W'(ROWS - 1));
  assign mid_row   = cur_rows[row_cnt];

  // Neighbour rows; the extended vectors carry one padding column on each
  // side so that column c's neighbourhood is always bits c..c+2
`ifdef LIFE_WRAP_EN
  assign up_row = first_row ? cur_rows[ROWS-1] : cur_rows[row_cnt - ROW_W'(1)];
  assign dn_row = last_row  ? cur_rows[0]      : cur_rows[row_cnt + ROW_W'(1)];
  assign up_e   = {up_row[0],  up_row,  up_row[COLS-1]};
  assign mid_e  = {mid_row[0], mid_row, mid_row[COLS-1]};
  assign dn_e   = {dn_row[0],  dn_row,  dn_row[COLS-1]};
`else
  assign up_row = first_row ? '0 : cur_rows[row_cnt - ROW_W'(1)];
  assign dn_row = last_row  ? '0 : cur_rows[row_cnt + ROW_W'(1)];
  assign up_e   = {1'b0, up_row,  1'b0};
  assign mid_e  = {1'b0, mid_row, 1'b0};
  assign dn_e   = {1'b0, dn_row,  1'b0};
`endif

  // Cell rule for every column of the row being computed: mid_e[c+1] is the
  // cell itself, the other eight bits of the 3x3 window are neighbours
  for (genvar c = 0; c < COLS; c++) begin : g_cells
    assign ncnt[c] = 4'(up_e[c])  + 4'(up_e[c+1]) + 4'(up_e[c+2])
                   + 4'(mid_e[c])                 + 4'(mid_e[c+2])
                   + 4'(dn_e[c])  + 4'(dn_e[c+1]) + 4'(dn_e[c+2]);
    assign row_next[c] = (ncnt[c] == 4'd3) | (mid_e[c+1] & (ncnt[c] == 4'd2));
  end

  // Control FSM; board_o only changes on load or commit, so the display
  // never sees a half-computed generation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      row_cnt     <= '0;
      board_r     <= '0;
      busy_r      <= 1'b0;
      gen_done_r  <= 1'b0;
      gen_count_r <= '0;
      extinct_r   <= 1'b0;
      stable_r    <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        next_rows[i] <= '0;
      end
    end else begin
      gen_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            board_r     <= bus.board_i;
            gen_count_r <= '0;
            extinct_r   <= 1'b0;
            stable_r    <= 1'b0;
          end else if (bus.step || (bus.run && bus.tick)) begin
            row_cnt <= '0;
            busy_r  <= 1'b1;
            state   <= COMPUTE;
          end
        end
        COMPUTE: begin
          next_rows[row_cnt] <= row_next;
          if (last_row) begin
            state <= COMMIT;
          end else begin
            row_cnt <= row_cnt + ROW_W'(1);
          end
        end
        COMMIT: begin
          board_r     <= next_flat;
          gen_count_r <= gen_count_r + GEN_W'(1);
          extinct_r   <= (next_flat == '0);
          stable_r    <= (next_flat == board_r);
          gen_done_r  <= 1'b1;
          busy_r      <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.board_o   = board_r;
  assign bus.busy      = busy_r;
  assign bus.gen_done  = gen_done_r;
  assign bus.gen_count = gen_count_r;
  assign bus.extinct   = extinct_r;
  assign bus.stable    = stable_r;

endmodule
